// File: rtl/bn_phase_sequencer.sv
// Upstream control for the 1-to-3 BN demux. Each batch is streamed three times
// (sum, range, normalize), and every accepted sample is registered with its phase select.
module bn_phase_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  batch_len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  batch_done,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PH_SUM  = 2'd1,
        PH_RNG  = 2'd2,
        PH_NORM = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, len_q;
    logic                 accept, last_in_phase, start_ok;
    logic [1:0]           phase_code;

    // Handshake: a transfer happens on a rising edge where valid && ready. in_ready
    // is high outside IDLE whenever the output register is empty or draining this
    // cycle; out_valid stays high and its payload stays stable until out_ready.
    always_comb begin
        in_ready      = (state != IDLE) && (!out_valid || out_ready);
        accept        = in_valid && in_ready;
        last_in_phase = (cnt == (len_q - CNT_WIDTH'(1)));
        start_ok      = (state == IDLE) && start && (batch_len != '0);
        phase_code    = 2'b11;
        state_nx      = state;
        case (state)
            IDLE: begin
                if (start_ok) state_nx = PH_SUM;
            end
            PH_SUM: begin
                phase_code = 2'b00;
                if (accept && last_in_phase) state_nx = PH_RNG;
            end
            PH_RNG: begin
                phase_code = 2'b01;
                if (accept && last_in_phase) state_nx = PH_NORM;
            end
            PH_NORM: begin
                phase_code = 2'b10;
                if (accept && last_in_phase) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            out_data   <= '0;
            out_sel    <= 2'b11;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            batch_done <= 1'b0;
        end else begin
            state      <= state_nx;
            batch_done <= (state == PH_NORM) && accept && last_in_phase;

            if (start_ok) begin
                len_q <= batch_len;
                cnt   <= '0;
            end else if (accept) begin
                cnt <= last_in_phase ? '0 : cnt + CNT_WIDTH'(1);
            end

            // Idle output parks on sel 2'b11 so the demux drives all branches to zero.
            if (accept) begin
                out_data  <= in_data;
                out_sel   <= phase_code;
                out_valid <= 1'b1;
                out_last  <= last_in_phase;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_sel   <= 2'b11;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bn_phase_sequencer.md
Name: bn_phase_sequencer

Overview:
- Upstream control stage for the 1-to-3 BN demultiplexer.
- Accepts one channel's activation stream and registers each sample with a 2-bit phase select, so the demux routes it to the correct BN datapath:
  - 2'b00: sum/mean accumulator
  - 2'b01: range/variance unit
  - 2'b10: normalize/scale unit
- Each batch is streamed three times, once per phase, in fixed order. Valid/ready handshakes are used on both sides.

Parameters:
- DATA_WIDTH, 16: width of the sample data path. Matches the demux DATA_WIDTH.
- CNT_WIDTH, 10: width of the batch-length port and the internal sample counter.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin a batch. Sampled only in IDLE.
- batch_len, input, CNT_WIDTH: samples per phase. Latched on an accepted start.
- in_data, input, DATA_WIDTH: upstream sample.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: the block accepts in_data this cycle.
- out_data, output, DATA_WIDTH: registered sample, drives demux in0.
- out_sel, output, 2: registered phase select, drives demux sel.
- out_valid, output, 1: out_data and out_sel are valid.
- out_ready, input, 1: downstream consumes the output this cycle.
- out_last, output, 1: out_data is the final sample of its phase.
- busy, output, 1: high in any state other than IDLE.
- batch_done, output, 1: one-cycle pulse when the batch completes.

Behaviour:
- **Reset values:** state = IDLE, cnt = 0, in_ready = 0, out_valid = 0, out_data = 0, out_sel = 2'b11, out_last = 0, busy = 0, batch_done = 0.
  - Reset mid-batch discards all state and any held output sample. No batch_done is issued.
- **FSM states:** IDLE, PH_SUM (sel 00), PH_RNG (sel 01), PH_NORM (sel 10).
- **Starting a batch:**
  - In IDLE, start=1 with batch_len!=0 latches batch_len into len_q, clears cnt and enters PH_SUM on the next cycle.
  - start with batch_len==0 is ignored; the block stays in IDLE.
  - start outside IDLE is ignored, including in the same cycle as batch completion.
- **Input handshake:**
  - in_ready = (state != IDLE) && (!out_valid || out_ready).
  - An accept occurs when in_valid && in_ready.
  - in_ready is 0 in IDLE, so upstream data in IDLE is never taken.
- **On accept:**
  - out_data <= in_data.
  - out_sel <= the current phase code.
  - out_valid <= 1.
  - out_last <= (cnt == len_q-1).
  - Latency from in to out is 1 cycle.
- **Counting and phase advance:**
  - cnt increments on each accept.
  - On an accept with cnt == len_q-1, cnt resets to 0 and the FSM advances PH_SUM -> PH_RNG -> PH_NORM -> IDLE.
- **Output hold and drain:**
  - When out_valid && !out_ready, out_data, out_sel and out_last are held stable.
  - When out_valid && out_ready with no new accept, out_valid <= 0 and out_sel <= 2'b11.
  - out_sel = 2'b11 whenever out_valid = 0. The demux then drives all three outputs to zero, so no branch sees a spurious sample.
  - out_sel is never 2'b11 while out_valid = 1.
- **Batch completion:** batch_done pulses for one cycle, in the cycle after the final PH_NORM sample is accepted (the cycle busy falls). It does not wait for that sample to drain from the output register.
- **Back-to-back start:** a start in the first IDLE cycle may be accepted while the final sample is still held in the output register. The new PH_SUM sample loads only after that sample drains.
- **Throughput:** one sample per cycle when out_ready is held at 1, with no bubble between phases.
- **len_q width:** len_q is CNT_WIDTH bits. The maximum batch is 2^CNT_WIDTH-1 samples.

Test Plan:
- **Basic batch:** reset, batch_len=3, start, in_valid=1 with data 1..9, out_ready=1.
  - out_sel sequence 00,00,00,01,01,01,10,10,10 with out_data 1..9.
  - out_last on samples 3, 6 and 9.
  - batch_done one cycle after sample 9 is accepted.
- **Downstream backpressure:** batch_len=2, out_ready=0 for 4 cycles after the first accept.
  - out_data and out_sel are held.
  - in_ready=0 during the stall.
  - No sample is lost or duplicated; total output is 6 samples.
- **Zero-length and busy starts:**
  - start with batch_len=0: busy stays 0.
  - start pulsed during PH_RNG: ignored; phase order and counts are unchanged.
- **Input gaps:** batch_len=4 with in_valid toggling 1,0,1,0.
  - cnt advances only on accepts.
  - out_valid drops to 0 and out_sel returns to 11 during gaps.
- **Reset mid-operation:** assert rst in PH_NORM after 1 sample.
  - Next cycle: out_valid=0, out_sel=11, busy=0, and no batch_done pulse.
  - A new batch with batch_len=1 produces exactly 3 samples, sel 00, 01, 10.
